// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the ram_db port arbiter: FSM state encoding, owner IDs and default widths.
package ram_port_arbiter_pkg;

    localparam int ARB_XLEN_DEF = 32;
    localparam int ARB_AW_DEF   = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_starve_cnt.sv
// Counts arbitrations requester 1 lost to requester 0; saturates at STARVE_MAX, never wraps.
// Updates one cycle after inc/clr; no backpressure, clr has priority over inc.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat = (cnt_q >= CNT_W'(STARVE_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter onto the ram_db port: fixed priority to m0 with a starvation guard for m1.
// ram_valid 1 cycle after a request is seen in IDLE; grant held until ram_ready, ready/rdata routed combinationally.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int XLEN       = ARB_XLEN_DEF,
    parameter int AW         = ARB_AW_DEF,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_valid,
    input  logic            m0_wr,
    input  logic            m0_rd,
    input  logic [AW-1:0]   m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_ready,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_valid,
    input  logic            m1_wr,
    input  logic            m1_rd,
    input  logic [AW-1:0]   m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_ready,
    output logic [XLEN-1:0] m1_rdata,

    output logic            ram_valid,
    output logic            ram_wr,
    output logic            ram_rd,
    output logic [AW-1:0]   ram_addr,
    output logic [XLEN-1:0] ram_wdata,
    input  logic [XLEN-1:0] ram_rdata,
    input  logic            ram_ready,

    output logic            arb_o_busy,
    output logic            arb_o_owner
);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_sat;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // m1 wins only when alone or once it has been starved STARVE_MAX times
                if (m1_valid && (!m0_valid || starve_sat)) begin
                    state_d    = ARB_GNT1;
                    owner_d    = ARB_M1;
                    wr_d       = m1_wr;
                    rd_d       = m1_rd;
                    addr_d     = m1_addr;
                    wdata_d    = m1_wdata;
                    starve_clr = 1'b1;
                end else if (m0_valid) begin
                    state_d    = ARB_GNT0;
                    owner_d    = ARB_M0;
                    wr_d       = m0_wr;
                    rd_d       = m0_rd;
                    addr_d     = m0_addr;
                    wdata_d    = m0_wdata;
                    starve_inc = m1_valid;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (ram_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_M0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ram_valid   = (state_q != ARB_IDLE);
    assign arb_o_busy  = (state_q != ARB_IDLE);
    assign arb_o_owner = owner_q;
    assign ram_wr      = wr_q;
    assign ram_rd      = rd_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;

    // ram_ready outside a grant never reaches either requester
    assign m0_ready = (state_q == ARB_GNT0) && ram_ready;
    assign m1_ready = (state_q == ARB_GNT1) && ram_ready;
    assign m0_rdata = m0_ready ? ram_rdata : '0;
    assign m1_rdata = m1_ready ? ram_rdata : '0;

endmodule
